coin_acceptor: RTL and testbench
================================

COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, is the number of consecutive cycles a synchronised sensor level must hold before it is accepted (range 1..15).
REQ-002 Parameter FIFO_DEPTH, default 4, is the number of pending coins buffered (power of two, 2..8).
REQ-003 Parameter GAP_CYCLES, default 1, is the number of idle cycles forced after each issued coin pulse (0..7).
REQ-004 clock  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 raw_nickel  input  1  unsynchronised, bouncing nickel sensor (high = coin present).
REQ-007 raw_dime  input  1  unsynchronised, bouncing dime sensor (high = coin present).
REQ-008 drain_en  input  1  downstream vending machine can accept coins (low while dispensing).
REQ-009 nickel_in  output  1  one-cycle pulse, one nickel credited to the vending machine.
REQ-010 dime_in  output  1  one-cycle pulse, one dime credited to the vending machine.
REQ-011 coin_return  output  1  one-cycle pulse, physical coin routed back to customer.
REQ-012 pending  output  $clog2(FIFO_DEPTH)+1  number of coins queued, not yet issued.

Function
REQ-013 Each raw sensor SHALL pass a 2-flop synchroniser, then a debouncer whose stable level changes only after DEBOUNCE_CYCLES consecutive cycles of the opposite synchronised level; any mismatch-free break restarts the count.
REQ-014 A coin event SHALL be a 0->1 transition of a debounced stable level; 1->0 transitions produce nothing.
REQ-015 A nickel event alone SHALL push NICKEL, a dime event alone SHALL push DIME into the FIFO on the next edge.
REQ-016 Nickel and dime events in the same cycle SHALL push nothing and pulse coin_return on the next cycle.
REQ-017 A push when pending == FIFO_DEPTH and no pop that cycle SHALL be dropped and pulse coin_return; push with simultaneous pop when full SHALL succeed.
REQ-018 Issue SHALL occur when drain_en == 1, pending > 0 and gap counter == 0: pop head, drive nickel_in or dime_in high for exactly one cycle (registered), load gap counter with GAP_CYCLES.
REQ-019 nickel_in and dime_in SHALL never be high in the same cycle; coins SHALL issue in arrival order.
REQ-020 Gap counter SHALL decrement every cycle while non-zero, regardless of drain_en.
REQ-021 drain_en low SHALL hold the FIFO contents; no coin is lost or reordered.
REQ-022 Latency: raw high sampled at edge k, stable thereafter, empty FIFO, drain_en high, gap 0 -> pulse high in the cycle following edge k+DEBOUNCE_CYCLES+3.
REQ-023 pending SHALL update on the same edge as each push/pop; simultaneous push and pop leave it unchanged.

Reset
REQ-024 reset low SHALL asynchronously clear synchronisers, debounce counters, stable levels (0), FIFO pointers, pending (0), gap counter (0) and all outputs (0).
REQ-025 Reset mid-operation SHALL discard queued coins without issuing or returning them; a sensor held high through reset release yields one event after debounce.

Structure
REQ-026 Package coin_acceptor_pkg SHALL hold coin type enum (NICKEL=0, DIME=1) and default parameter constants.
REQ-027 Sub-module coin_debounce (synchroniser + counter + edge detect) SHALL be instantiated once per sensor.

Verification
REQ-028 Defaults; raw_nickel high 1 cycle then low -> no nickel_in, pending stays 0.
REQ-029 Defaults; raw_dime bounces 3 toggles then held high -> exactly one dime_in pulse, 7 cycles after first stable sampling edge.
REQ-030 Defaults; nickel, dime, nickel queued with drain_en low -> pending = 3; raise drain_en -> pulses nickel, dime, nickel, each separated by 1 idle cycle, pending returns to 0.
REQ-031 Defaults, drain_en low; 5 nickel events -> pending = 4, one coin_return pulse on 5th.
REQ-032 Both sensors rise same cycle -> one coin_return pulse, pending unchanged, no credit pulse.
REQ-033 Assert reset with pending = 2 mid-gap -> all outputs 0 immediately, pending 0, no pulses after release.

Source files
------------

// File: rtl/coin_acceptor_pkg.sv
// Shared types and default constants for the coin acceptor.
package coin_acceptor_pkg;

  typedef enum logic {
    NICKEL = 1'b0,
    DIME   = 1'b1
  } coin_t;

  localparam int DEF_DEBOUNCE_CYCLES = 4;
  localparam int DEF_FIFO_DEPTH      = 4;
  localparam int DEF_GAP_CYCLES      = 1;

  // Debounce counter covers 1..15, gap counter covers 0..7.
  localparam int CNT_W = 4;
  localparam int GAP_W = 3;

endpackage

// File: rtl/coin_debounce.sv
// Sensor front end: 2-flop synchroniser, consecutive-cycle debouncer and a
// registered one-cycle pulse on each accepted 0->1 change of the stable level.
import coin_acceptor_pkg::*;

module coin_debounce #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic rise
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             stable;
  logic [CNT_W-1:0] cnt;
  logic             mismatch;

  assign mismatch = sync_2 ^ stable;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= raw;
      sync_2 <= sync_1;
    end
  end

  // The count only advances while the synchronised level disagrees with the
  // stable level; any cycle of agreement throws the partial count away.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stable <= 1'b0;
      cnt    <= '0;
      rise   <= 1'b0;
    end else begin
      rise <= 1'b0;
      if (mismatch) begin
        if (cnt == CNT_LAST) begin
          stable <= sync_2;
          cnt    <= '0;
          rise   <= sync_2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: debounced nickel/dime sensors feed an in-order coin FIFO that
// is drained as one-cycle credit pulses, spaced by a programmable idle gap.
import coin_acceptor_pkg::*;

module coin_acceptor #(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int FIFO_DEPTH      = DEF_FIFO_DEPTH,
  parameter int GAP_CYCLES      = DEF_GAP_CYCLES
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        raw_nickel,
  input  logic                        raw_dime,
  input  logic                        drain_en,
  output logic                        nickel_in,
  output logic                        dime_in,
  output logic                        coin_return,
  output logic [$clog2(FIFO_DEPTH):0] pending
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0]    FULL_LEVEL = PW'(FIFO_DEPTH);
  localparam logic [GAP_W-1:0] GAP_LOAD   = GAP_W'(GAP_CYCLES);

  logic nickel_rise;
  logic dime_rise;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_nickel (
    .clock (clock),
    .reset (reset),
    .raw   (raw_nickel),
    .rise  (nickel_rise)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_dime (
    .clock (clock),
    .reset (reset),
    .raw   (raw_dime),
    .rise  (dime_rise)
  );

  coin_t            mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [GAP_W-1:0] gap;

  logic  push_req;
  logic  both;
  logic  full;
  logic  pop;
  logic  push;
  logic  drop;
  coin_t push_coin;
  coin_t head_coin;

  // Handshake: a single coin event is a push request that is accepted when the
  // FIFO has room or is popped in the same cycle; otherwise it is refused and
  // becomes coin_return. Pop is the consumer side: drain_en acts as ready,
  // pending != 0 as valid, and the gap counter blocks pops while non-zero.
  always_comb begin
    both      = nickel_rise & dime_rise;
    push_req  = nickel_rise ^ dime_rise;
    push_coin = dime_rise ? DIME : NICKEL;
    full      = (pending == FULL_LEVEL);
    pop       = drain_en && (pending != '0) && (gap == '0);
    push      = push_req && (!full || pop);
    drop      = both || (push_req && full && !pop);
    head_coin = mem[rd_ptr];
  end

  // Storage needs no reset: entries are only read behind a non-zero pending.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_coin;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      pending <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   pending <= pending + 1'b1;
        2'b01:   pending <= pending - 1'b1;
        default: pending <= pending;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      gap <= '0;
    end else if (pop) begin
      gap <= GAP_LOAD;
    end else if (gap != '0) begin
      gap <= gap - 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      nickel_in   <= 1'b0;
      dime_in     <= 1'b0;
      coin_return <= 1'b0;
    end else begin
      nickel_in   <= pop && (head_coin == NICKEL);
      dime_in     <= pop && (head_coin == DIME);
      coin_return <= drop;
    end
  end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor at default parameters.
module tb_coin_acceptor;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       raw_nickel = 1'b0;
  logic       raw_dime = 1'b0;
  logic       drain_en = 1'b1;
  logic       nickel_in;
  logic       dime_in;
  logic       coin_return;
  logic [2:0] pending;

  int checks = 0;
  int errors = 0;
  int n_cnt = 0;
  int d_cnt = 0;
  int r_cnt = 0;

  logic [1:0] exp_q[$];

  coin_acceptor dut (
    .clock       (clock),
    .reset       (reset),
    .raw_nickel  (raw_nickel),
    .raw_dime    (raw_dime),
    .drain_en    (drain_en),
    .nickel_in   (nickel_in),
    .dime_in     (dime_in),
    .coin_return (coin_return),
    .pending     (pending)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic coin(input logic nk, input logic dm);
    raw_nickel = nk;
    raw_dime   = dm;
    tick(8);
    raw_nickel = 1'b0;
    raw_dime   = 1'b0;
    tick(8);
  endtask

  // Scoreboard: every credit pulse must match the oldest expected coin.
  always @(negedge clock) begin
    logic [1:0] want;
    if (nickel_in) n_cnt++;
    if (dime_in)   d_cnt++;
    if (coin_return) r_cnt++;
    if (nickel_in || dime_in) begin
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 2'd2;
      check("issue_order", {1'b0, dime_in}, want);
      check("credit_exclusive", nickel_in & dime_in, 0);
    end
  end

  initial begin
    int n0, d0, r0;
    logic early;
    logic [6:0] nick_pat, dime_pat;

    // Reset state
    tick(3);
    check("reset_nickel_in", nickel_in, 0);
    check("reset_dime_in", dime_in, 0);
    check("reset_coin_return", coin_return, 0);
    check("reset_pending", pending, 0);
    reset = 1'b1;
    tick(3);

    // Single-cycle glitch is rejected
    n0 = n_cnt;
    raw_nickel = 1'b1;
    tick(1);
    raw_nickel = 1'b0;
    tick(12);
    check("glitch_no_nickel", n_cnt - n0, 0);
    check("glitch_pending", pending, 0);

    // Bouncing dime: one pulse, 7 cycles after the first stable sampling edge
    d0 = d_cnt;
    exp_q.push_back(2'd1);
    raw_dime = 1'b1;
    tick(1);
    raw_dime = 1'b0;
    tick(1);
    raw_dime = 1'b1;
    early = 1'b0;
    for (int i = 1; i <= 7; i++) begin
      tick(1);
      early |= dime_in;
    end
    check("bounce_no_early_pulse", early, 0);
    check("bounce_pending_before_issue", pending, 1);
    tick(1);
    check("bounce_dime_latency", dime_in, 1);
    check("bounce_pending_after_issue", pending, 0);
    tick(1);
    check("bounce_dime_one_cycle", dime_in, 0);
    tick(10);
    raw_dime = 1'b0;
    tick(10);
    check("bounce_dime_count", d_cnt - d0, 1);

    // Queue N, D, N while held, then drain with a 1-cycle gap
    drain_en = 1'b0;
    n0 = n_cnt;
    d0 = d_cnt;
    coin(1'b1, 1'b0);
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    check("hold_pending_3", pending, 3);
    check("hold_no_credits", (n_cnt - n0) + (d_cnt - d0), 0);
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    drain_en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick(1);
      nick_pat[i] = nickel_in;
      dime_pat[i] = dime_in;
    end
    check("drain_nickel_pattern", nick_pat, 7'b0010001);
    check("drain_dime_pattern", dime_pat, 7'b0000100);
    check("drain_pending_0", pending, 0);

    // Overflow: fifth coin is returned; then push with pop while full succeeds
    drain_en = 1'b0;
    n0 = n_cnt;
    d0 = d_cnt;
    r0 = r_cnt;
    repeat (5) coin(1'b1, 1'b0);
    check("overflow_pending_4", pending, 4);
    check("overflow_one_return", r_cnt - r0, 1);
    check("overflow_no_credit", n_cnt - n0, 0);
    repeat (4) exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    raw_dime = 1'b1;
    tick(6);
    drain_en = 1'b1;
    tick(1);
    check("full_push_pop_pending", pending, 4);
    check("full_push_pop_nickel", nickel_in, 1);
    check("full_push_pop_no_return", coin_return, 0);
    raw_dime = 1'b0;
    tick(16);
    check("full_flush_pending", pending, 0);
    check("full_flush_nickels", n_cnt - n0, 4);
    check("full_flush_dimes", d_cnt - d0, 1);
    check("full_flush_returns", r_cnt - r0, 1);

    // Simultaneous sensors: returned, nothing credited or queued
    n0 = n_cnt;
    d0 = d_cnt;
    r0 = r_cnt;
    coin(1'b1, 1'b1);
    check("both_one_return", r_cnt - r0, 1);
    check("both_no_credit", (n_cnt - n0) + (d_cnt - d0), 0);
    check("both_pending", pending, 0);

    // Reset mid-gap with two coins still queued
    drain_en = 1'b0;
    coin(1'b1, 1'b0);
    coin(1'b0, 1'b1);
    coin(1'b1, 1'b0);
    exp_q.push_back(2'd0);
    drain_en = 1'b1;
    tick(1);
    check("midgap_pending_2", pending, 2);
    #2 reset = 1'b0;
    #1;
    check("async_reset_nickel_in", nickel_in, 0);
    check("async_reset_dime_in", dime_in, 0);
    check("async_reset_coin_return", coin_return, 0);
    check("async_reset_pending", pending, 0);
    tick(3);
    reset = 1'b1;
    n0 = n_cnt;
    d0 = d_cnt;
    r0 = r_cnt;
    tick(20);
    check("post_reset_no_pulses", (n_cnt - n0) + (d_cnt - d0) + (r_cnt - r0), 0);
    check("post_reset_pending", pending, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
